// File: rtl/t08_imem_responder.sv
// Instruction-fetch responder: turns fetch requests into single bus reads, stalls fetch while busy.
// Optional one-entry last-hit buffer is enabled with `define T08_IMEM_LASTHIT_EN.
module t08_imem_responder #(
  parameter int          TIMEOUT_CYCLES = 16,
  parameter logic [31:0] NOP_INSTR      = 32'h00000013
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        fetch_req,
  input  logic [31:0] pc_in,
  input  logic        flush,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic        instr_fault,
  output logic        freeze,
  output logic        mem_read,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] COUNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic          drop;
  logic          lh_hit;

`ifdef T08_IMEM_LASTHIT_EN
  logic        lh_valid;
  logic [31:0] lh_addr;
  logic [31:0] lh_data;
  assign lh_hit = lh_valid && (pc_in == lh_addr);
`else
  assign lh_hit = 1'b0;
`endif

  assign freeze = (state != IDLE) | ((state == IDLE) & fetch_req);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= IDLE;
      count       <= '0;
      drop        <= 1'b0;
      instruction <= NOP_INSTR;
      instr_valid <= 1'b0;
      instr_fault <= 1'b0;
      mem_read    <= 1'b0;
      mem_addr    <= '0;
`ifdef T08_IMEM_LASTHIT_EN
      lh_valid    <= 1'b0;
      lh_addr     <= '0;
      lh_data     <= '0;
`endif
    end else begin
      instr_valid <= 1'b0;
      instr_fault <= 1'b0;
      mem_read    <= 1'b0;
      case (state)
        IDLE: begin
          drop <= 1'b0;
          if (fetch_req) begin
            if (pc_in[1:0] != 2'b00) begin
              instr_fault <= 1'b1;
              instruction <= NOP_INSTR;
`ifdef T08_IMEM_LASTHIT_EN
              lh_valid    <= 1'b0;
`endif
            end else if (lh_hit) begin
`ifdef T08_IMEM_LASTHIT_EN
              instruction <= lh_data;
`endif
              instr_valid <= 1'b1;
            end else begin
              // mem_read is raised here so it is high for exactly the REQ cycle
              mem_addr <= pc_in;
              mem_read <= 1'b1;
              state    <= REQ;
            end
          end
        end
        REQ: begin
          count <= '0;
          state <= WAIT;
          if (flush) drop <= 1'b1;
        end
        WAIT: begin
          if (mem_ack) begin
            state <= IDLE;
            if (!(drop || flush)) begin
              instruction <= mem_rdata;
              instr_valid <= 1'b1;
`ifdef T08_IMEM_LASTHIT_EN
              lh_valid    <= 1'b1;
              lh_addr     <= mem_addr;
              lh_data     <= mem_rdata;
`endif
            end
          end else if (count == COUNT_LAST) begin
            state <= IDLE;
            if (!(drop || flush)) begin
              instruction <= NOP_INSTR;
              instr_fault <= 1'b1;
`ifdef T08_IMEM_LASTHIT_EN
              lh_valid    <= 1'b0;
`endif
            end
          end else begin
            count <= count + 1'b1;
            if (flush) drop <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_t08_imem_responder.sv
// Scoreboard bench for t08_imem_responder: driver pushes expected deliveries and bus addresses,
// a negedge monitor pops and compares whenever the DUT pulses.
module tb_t08_imem_responder;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        fetch_req = 1'b0;
  logic [31:0] pc_in = '0;
  logic        flush = 1'b0;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        instr_fault;
  logic        freeze;
  logic        mem_read;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  t08_imem_responder #(.TIMEOUT_CYCLES(16), .NOP_INSTR(NOP)) dut (
    .clk(clk), .nrst(nrst), .fetch_req(fetch_req), .pc_in(pc_in), .flush(flush),
    .instruction(instruction), .instr_valid(instr_valid), .instr_fault(instr_fault),
    .freeze(freeze), .mem_read(mem_read), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          fault;
    logic [31:0] instr;
    int          at;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] addr_q[$];
  int          total = 0;
  int          passed = 0;

  // reference model state: what fetch should currently see, and the last-hit buffer
  logic [31:0] m_instr = NOP;
  bit          lh_valid = 1'b0;
  logic [31:0] lh_addr = '0;
  logic [31:0] lh_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    else passed++;
  endtask

  // monitor
  always @(negedge clk) begin
    if (nrst === 1'b1) begin
      if (mem_read) begin
        if (addr_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_mem_read: got addr %h expected no read (cycle %0d)", mem_addr, cyc);
        end else begin
          logic [31:0] a;
          a = addr_q.pop_front();
          chk("mem_addr", mem_addr, a);
          $display("bus read addr=%h cycle=%0d", mem_addr, cyc);
        end
      end
      if (instr_valid || instr_fault) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_pulse: got valid=%0b fault=%0b expected none (cycle %0d)",
                   instr_valid, instr_fault, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("pulse_kind", {30'd0, instr_valid, instr_fault}, e.fault ? 32'd1 : 32'd2);
          chk("instruction", instruction, e.instr);
          chk("pulse_cycle", cyc, e.at);
          chk("freeze_release", {31'd0, freeze}, {31'd0, fetch_req});
          $display("deliver valid=%0b fault=%0b instr=%h cycle=%0d", instr_valid, instr_fault,
                   instruction, cyc);
        end
      end
    end
  end

  // One fetch. delay = WAIT cycles before ack (>15 means no ack -> timeout).
  // fl = cycle of flush: -1 in REQ, 0.. in WAIT, anything larger = no flush.
  task automatic do_fetch(input logic [31:0] pc, input int delay, input int fl, input logic [31:0] data);
    int  c0;
    int  wend;
    bit  drop;
    bit  hit;
    exp_t e;
    fetch_req = 1'b1;
    pc_in     = pc;
    c0        = cyc;
`ifdef T08_IMEM_LASTHIT_EN
    hit = lh_valid && (lh_addr == pc);
`else
    hit = 1'b0;
`endif
    @(posedge clk); #1;
    fetch_req = 1'b0;
    pc_in     = $urandom;
    if (pc[1:0] != 2'b00) begin
      e = '{1'b1, NOP, c0 + 1};
      exp_q.push_back(e);
      m_instr  = NOP;
      lh_valid = 1'b0;
    end else if (hit) begin
      e = '{1'b0, lh_data, c0 + 1};
      exp_q.push_back(e);
      m_instr = lh_data;
    end else begin
      addr_q.push_back(pc);
      wend = (delay > 15) ? 15 : delay;
      drop = (fl <= wend);
      if (!drop) begin
        if (delay <= 15) begin
          e = '{1'b0, data, c0 + 3 + delay};
          m_instr  = data;
          lh_valid = 1'b1;
          lh_addr  = pc;
          lh_data  = data;
        end else begin
          e = '{1'b1, NOP, c0 + 18};
          m_instr  = NOP;
          lh_valid = 1'b0;
        end
        exp_q.push_back(e);
      end
      flush = (fl == -1);
      @(posedge clk); #1;
      flush = 1'b0;
      for (int w = 0; w <= wend; w++) begin
        mem_ack   = (w == delay);
        flush     = (w == fl);
        mem_rdata = (w == delay) ? data : $urandom;
        @(negedge clk);
        chk("freeze_busy", {31'd0, freeze}, 32'd1);
        @(posedge clk); #1;
      end
      mem_ack = 1'b0;
      flush   = 1'b0;
      if (delay > 15) begin
        // stray ack after the timeout must be ignored
        mem_ack   = 1'b1;
        mem_rdata = $urandom;
        @(posedge clk); #1;
        mem_ack = 1'b0;
      end
      if (drop) begin
        @(negedge clk);
        chk("drop_hold", instruction, m_instr);
      end
    end
    repeat (2) begin
      flush = ($urandom_range(0, 3) == 0);
      @(posedge clk); #1;
    end
    flush = 1'b0;
  endtask

  task automatic reset_mid_wait();
    addr_q.push_back(32'h300);
    fetch_req = 1'b1;
    pc_in     = 32'h300;
    @(posedge clk); #1;
    fetch_req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    nrst      = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'hCAFEF00D;
    #1;
    chk("rst_instruction", instruction, NOP);
    chk("rst_pulses", {30'd0, instr_valid, instr_fault}, 32'd0);
    chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
    chk("rst_freeze", {31'd0, freeze}, 32'd0);
    @(posedge clk); #1;
    mem_ack  = 1'b0;
    nrst     = 1'b1;
    m_instr  = NOP;
    lh_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] pool [4];
    logic [31:0] d;
    pool[0] = 32'h100; pool[1] = 32'h200; pool[2] = 32'h204; pool[3] = 32'h208;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_instruction", instruction, NOP);
    chk("reset_pulses", {30'd0, instr_valid, instr_fault}, 32'd0);
    chk("reset_mem_read", {31'd0, mem_read}, 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    chk("reset_freeze", {31'd0, freeze}, 32'd0);
    nrst = 1'b1;
    @(posedge clk); #1;

    do_fetch(32'h100, 0, 99, 32'h00A00093);
    do_fetch(32'h180, 5, 99, 32'h12345678);
    do_fetch(32'h140, 16, 99, 32'h0BADF00D);
    do_fetch(32'h1C0, 1, 0, 32'hDEADBEEF);
    do_fetch(32'h10A, 0, 99, 32'h0);
    do_fetch(32'h1C4, 0, -1, 32'h55AA55AA);
    d = 32'h00500113;
    do_fetch(32'h200, 2, 99, d);
    do_fetch(32'h200, 0, 99, d);
    reset_mid_wait();
    do_fetch(32'h200, 0, 99, 32'h00700193);

    for (int t = 0; t < 60; t++) begin
      logic [31:0] pc;
      int delay;
      int wend;
      int fl;
      if ($urandom_range(0, 99) < 15)
        pc = ($urandom_range(0, 255) << 2) | $urandom_range(1, 3);
      else if ($urandom_range(0, 1) == 1)
        pc = pool[$urandom_range(0, 3)];
      else
        pc = $urandom & 32'hFFFF_FFFC;
      delay = ($urandom_range(0, 9) == 0) ? 16 : $urandom_range(0, 6);
      wend  = (delay > 15) ? 15 : delay;
      fl    = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, wend + 2)) - 1 : 99;
      do_fetch(pc, delay, fl, $urandom);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("pending_deliveries", exp_q.size(), 32'd0);
    chk("pending_bus_reads", addr_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
